result_drain: RTL and testbench

RESULT_DRAIN -- requirements
Module: result_drain

---
 rtl/tpu_pkg.sv | 18 +
 rtl/result_snapshot.sv | 44 ++++
 rtl/result_drain.sv | 121 ++++++++++++
 tb/tb_result_drain.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Shared TPU definitions: default array geometry, the result-drain state
// encoding and a helper for sizing row-index counters.
package tpu_pkg;

  localparam int MATRIX_SIZE = 8;   // systolic array dimension (N x N)
  localparam int ACC_SIZE    = 32;  // signed accumulator width per element

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } drain_state_e;

  // Width of a counter that addresses n rows; never narrower than 1 bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/result_snapshot.sv
// Result snapshot store: captures a full N x N result array in one edge and
// exposes one row at a time through a combinational read port.
//
// Ports:
//   clk          - clock, rising edge
//   rst_n        - asynchronous active-low reset, clears the whole snapshot
//   capture_en_i - load wr_array_i into the snapshot on this edge
//   wr_array_i   - full N x N array to capture
//   rd_idx_i     - row address for the read port
//   rd_row_o     - snapshot row rd_idx_i
module result_snapshot
  import tpu_pkg::*;
#(
  parameter  int matrixSize = MATRIX_SIZE,
  parameter  int accSize    = ACC_SIZE,
  localparam int IdxW       = idx_width(matrixSize)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      capture_en_i,
  input  logic signed [accSize-1:0] wr_array_i [matrixSize][matrixSize],
  input  logic        [IdxW-1:0]    rd_idx_i,
  output logic signed [accSize-1:0] rd_row_o   [matrixSize]
);

  logic signed [accSize-1:0] snap_q [matrixSize][matrixSize];

  // NOTE: this storage is reset on purpose so the row output reads 0 after
  // reset; plain RAM-style storage would normally be left unreset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < matrixSize; r++) begin
        for (int c = 0; c < matrixSize; c++) begin
          snap_q[r][c] <= '0;
        end
      end
    end else if (capture_en_i) begin
      snap_q <= wr_array_i;
    end
  end

  assign rd_row_o = snap_q[rd_idx_i];

endmodule

// File: rtl/result_drain.sv
// Result drain: snapshots the systolic array output on captureStrobe and
// streams it out one row per valid/ready handshake, rows 0..N-1 in order.
//
// Ports:
//   clk           - clock, rising edge
//   reset         - asynchronous active-low reset
//   captureStrobe - one-cycle pulse, resultArray valid in this cycle
//   resultArray   - N x N signed results from the systolic array
//   rowValid      - rowData/rowIndex hold a valid row (registered, == busy)
//   rowReady      - downstream accepts the current row
//   rowData       - current result row
//   rowIndex      - row number of rowData
//   lastRow       - rowValid and rowIndex == N-1
//   busy          - a snapshot is being drained
//   overrun       - sticky: a capture arrived while busy and was dropped
//   clearOverrun  - synchronous clear of overrun (a new overrun wins)
module result_drain
  import tpu_pkg::*;
#(
  parameter  int matrixSize = MATRIX_SIZE,
  parameter  int accSize    = ACC_SIZE,
  localparam int IdxW       = idx_width(matrixSize)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      captureStrobe,
  input  logic signed [accSize-1:0] resultArray [matrixSize][matrixSize],
  output logic                      rowValid,
  input  logic                      rowReady,
  output logic signed [accSize-1:0] rowData [matrixSize],
  output logic        [IdxW-1:0]    rowIndex,
  output logic                      lastRow,
  output logic                      busy,
  output logic                      overrun,
  input  logic                      clearOverrun
);

  localparam logic [IdxW-1:0] LastIdx = IdxW'(matrixSize - 1);

  drain_state_e    state_q, state_d;
  logic [IdxW-1:0] row_idx_q, row_idx_d;
  logic            overrun_q, overrun_d;

  logic xfer;         // handshake completes on this edge
  logic accept;       // capture is taken into the snapshot on this edge
  logic overrun_evt;  // capture is dropped on this edge

  assign busy     = (state_q == STREAM);
  assign rowValid = busy;
  assign lastRow  = busy && (row_idx_q == LastIdx);
  assign rowIndex = row_idx_q;
  assign overrun  = overrun_q;

  assign xfer = rowValid && rowReady;
  // A capture is legal when idle, or when the final row leaves on this same
  // edge, which lets back-to-back results stream without a bubble.
  assign accept      = captureStrobe && (!busy || (xfer && lastRow));
  assign overrun_evt = captureStrobe && !accept;

  // NOTE: every output of this block gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    row_idx_d = row_idx_q;
    overrun_d = overrun_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = STREAM;
          row_idx_d = '0;
        end
      end
      STREAM: begin
        if (xfer) begin
          if (lastRow) begin
            row_idx_d = '0;
            state_d   = accept ? STREAM : IDLE;
          end else begin
            row_idx_d = row_idx_q + IdxW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Set has priority over clear so a lost capture is never hidden.
    if (overrun_evt) begin
      overrun_d = 1'b1;
    end else if (clearOverrun) begin
      overrun_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      row_idx_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_idx_q <= row_idx_d;
      overrun_q <= overrun_d;
    end
  end

  result_snapshot #(
    .matrixSize(matrixSize),
    .accSize   (accSize)
  ) u_snapshot (
    .clk         (clk),
    .rst_n       (reset),
    .capture_en_i(accept),
    .wr_array_i  (resultArray),
    .rd_idx_i    (row_idx_q),
    .rd_row_o    (rowData)
  );

endmodule

// File: tb/tb_result_drain.sv
// Self-checking bench for result_drain: directed scenarios plus a random
// phase, all compared every cycle against a queue-based row model.
module tb_result_drain;
  import tpu_pkg::*;

  localparam int N   = 8;
  localparam int ACC = 32;

  logic clk           = 1'b0;
  logic reset         = 1'b0;
  logic captureStrobe = 1'b0;
  logic rowReady      = 1'b0;
  logic clearOverrun  = 1'b0;
  logic signed [ACC-1:0] resultArray [N][N];
  logic signed [ACC-1:0] rowData [N];
  logic        [2:0]     rowIndex;
  logic rowValid, lastRow, busy, overrun;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  result_drain #(.matrixSize(N), .accSize(ACC)) dut (
    .clk          (clk),
    .reset        (reset),
    .captureStrobe(captureStrobe),
    .resultArray  (resultArray),
    .rowValid     (rowValid),
    .rowReady     (rowReady),
    .rowData      (rowData),
    .rowIndex     (rowIndex),
    .lastRow      (lastRow),
    .busy         (busy),
    .overrun      (overrun),
    .clearOverrun (clearOverrun)
  );

  task automatic check(input string name, input logic [ACC-1:0] act, input logic [ACC-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Pending output rows in emission order; the head is what must be shown.
  typedef struct packed {
    logic [2:0]       idx;
    logic [N*ACC-1:0] data;
  } row_t;

  row_t exp_q[$];
  bit   m_overrun = 1'b0;

  always @(posedge clk or negedge reset) begin : model
    bit   last_leaves;
    bit   take;
    row_t t;
    if (!reset) begin
      exp_q.delete();
      m_overrun = 1'b0;
    end else begin
      last_leaves = (exp_q.size() == 1) && rowReady;
      take        = captureStrobe && ((exp_q.size() == 0) || last_leaves);
      if ((exp_q.size() != 0) && rowReady) void'(exp_q.pop_front());
      if (take) begin
        for (int r = 0; r < N; r++) begin
          t.idx = 3'(r);
          for (int c = 0; c < N; c++) t.data[c*ACC +: ACC] = resultArray[r][c];
          exp_q.push_back(t);
        end
      end
      if (captureStrobe && !take) m_overrun = 1'b1;
      else if (clearOverrun)      m_overrun = 1'b0;
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin : compare
    bit ev;
    bit exp_last;
    ev       = (exp_q.size() != 0);
    exp_last = 1'b0;
    if (ev) exp_last = (exp_q[0].idx == 3'd7);
    check("rowValid", {31'b0, rowValid}, {31'b0, ev});
    check("busy",     {31'b0, busy},     {31'b0, ev});
    check("lastRow",  {31'b0, lastRow},  {31'b0, exp_last});
    check("overrun",  {31'b0, overrun},  {31'b0, m_overrun});
    if (ev) begin
      check("rowIndex", {29'b0, rowIndex}, {29'b0, exp_q[0].idx});
      for (int c = 0; c < N; c++)
        check("rowData", rowData[c], exp_q[0].data[c*ACC +: ACC]);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int base);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) resultArray[r][c] = base + r*8 + c;
  endtask

  task automatic drain_out(input string name);
    int n;
    n = 0;
    rowReady = 1'b1;
    while (busy && n < 40) begin
      cycle();
      n++;
    end
    check(name, {31'b0, busy}, 32'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n;
    fill(0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_rowValid", {31'b0, rowValid}, 32'd0);
    check("rst_busy",     {31'b0, busy},     32'd0);
    check("rst_overrun",  {31'b0, overrun},  32'd0);
    check("rst_rowIndex", {29'b0, rowIndex}, 32'd0);
    check("rst_rowData0", rowData[0],        32'd0);

    // Scenario 1: capture in first cycle after release, rowReady held high
    reset = 1'b1;
    captureStrobe = 1'b1;
    rowReady = 1'b1;
    cycle();
    captureStrobe = 1'b0;
    check("s1_row0_idx", {29'b0, rowIndex}, 32'd0);
    check("s1_row0_e0",  rowData[0],        32'd0);
    repeat (3) cycle();
    check("s1_row3_idx", {29'b0, rowIndex}, 32'd3);
    for (int c = 0; c < N; c++) check("s1_row3_data", rowData[c], 32'(24 + c));
    check("s1_row3_last", {31'b0, lastRow}, 32'd0);
    repeat (4) cycle();
    check("s1_row7_idx",  {29'b0, rowIndex}, 32'd7);
    check("s1_row7_last", {31'b0, lastRow},  32'd1);
    cycle();
    check("s1_busy_after", {31'b0, busy}, 32'd0);

    // Scenario 2: rowReady pattern 1,0,0,1,...
    captureStrobe = 1'b1;
    rowReady = 1'b0;
    cycle();
    captureStrobe = 1'b0;
    n = 0;
    while (busy && n < 60) begin
      rowReady = ((n % 4) == 0) || ((n % 4) == 3);
      cycle();
      n++;
    end
    check("s2_drained", {31'b0, busy}, 32'd0);
    check("s2_cycles",  32'(n), 32'd16);

    // Scenario 3: source changes after capture
    captureStrobe = 1'b1;
    rowReady = 1'b0;
    cycle();
    captureStrobe = 1'b0;
    fill(0);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) resultArray[r][c] = -1;
    cycle();
    check("s3_row0_e5", rowData[5], 32'd5);
    drain_out("s3_drained");
    fill(0);

    // Scenario 4: overrun at rowIndex 2
    captureStrobe = 1'b1;
    rowReady = 1'b1;
    cycle();
    captureStrobe = 1'b0;
    repeat (2) cycle();
    fill(500);
    captureStrobe = 1'b1;
    cycle();
    captureStrobe = 1'b0;
    check("s4_overrun_set", {31'b0, overrun},  32'd1);
    check("s4_row3_e0",     rowData[0],        32'd24);
    drain_out("s4_drained");
    check("s4_overrun_hold", {31'b0, overrun}, 32'd1);
    clearOverrun = 1'b1;
    cycle();
    clearOverrun = 1'b0;
    check("s4_overrun_clr", {31'b0, overrun}, 32'd0);
    fill(0);

    // Scenario 5: capture on the row-7 transfer edge
    captureStrobe = 1'b1;
    rowReady = 1'b1;
    cycle();
    captureStrobe = 1'b0;
    repeat (7) cycle();
    check("s5_at_row7", {29'b0, rowIndex}, 32'd7);
    fill(1000);
    captureStrobe = 1'b1;
    cycle();
    captureStrobe = 1'b0;
    check("s5_idx0",    {29'b0, rowIndex}, 32'd0);
    check("s5_e0",      rowData[0],        32'd1000);
    check("s5_busy",    {31'b0, busy},     32'd1);
    check("s5_overrun", {31'b0, overrun},  32'd0);
    drain_out("s5_drained");
    fill(0);

    // Scenario 6: reset at rowIndex 4 (with overrun set beforehand)
    captureStrobe = 1'b1;
    rowReady = 1'b1;
    cycle();
    cycle();
    cycle();  // overrun capture at row 1 transfer
    captureStrobe = 1'b0;
    cycle();
    cycle();
    check("s6_at_row4", {29'b0, rowIndex}, 32'd4);
    check("s6_ovr_pre", {31'b0, overrun},  32'd1);
    reset = 1'b0;
    #1;
    check("s6_rowValid", {31'b0, rowValid}, 32'd0);
    check("s6_busy",     {31'b0, busy},     32'd0);
    check("s6_lastRow",  {31'b0, lastRow},  32'd0);
    check("s6_overrun",  {31'b0, overrun},  32'd0);
    check("s6_rowIndex", {29'b0, rowIndex}, 32'd0);
    for (int c = 0; c < N; c++) check("s6_rowData", rowData[c], 32'd0);
    cycle();
    reset = 1'b1;
    repeat (5) begin
      cycle();
      check("s6_no_rows", {31'b0, rowValid}, 32'd0);
    end

    // Random phase
    for (int i = 0; i < 2000; i++) begin
      captureStrobe = ($urandom_range(0, 9) == 0);
      rowReady      = ($urandom_range(0, 3) != 0);
      clearOverrun  = ($urandom_range(0, 15) == 0);
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) resultArray[r][c] = $urandom;
      cycle();
    end
    captureStrobe = 1'b0;
    clearOverrun  = 1'b0;
    drain_out("rand_drained");
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
